// File: rtl/arctan_scheduler_pkg.sv
// Shared types and constants for the arctan scheduler: FSM encoding, Q16.16 constants,
// default sizing. The WAIT timeout is only built with ARCTAN_SCHED_TIMEOUT_EN.
package arctan_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [31:0] ONE         = 32'h0001_0000;
    localparam int          K           = 39796;
    localparam int          DEF_N       = 4;
    localparam int          DEF_W       = 32;
    localparam int          DEF_TIMEOUT = 64;

endpackage

// File: rtl/arctan_scheduler_if.sv
// Requester and core-side signals of the arctan scheduler. The scheduler takes the
// slave modport; the requesters plus the arctan core together form the master side.
interface arctan_scheduler_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic [N-1:0]        req_valid;
    logic [N-1:0][W-1:0] req_tan;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        rsp_valid;
    logic [N-1:0]        rsp_ready;
    logic [W-1:0]        rsp_xita;
    logic                rsp_err;
    logic                core_start;
    logic [W-1:0]        core_tan;
    logic                core_valid;
    logic [W-1:0]        core_xita;

    modport slave (
        input  req_valid, req_tan, rsp_ready, core_valid, core_xita,
        output req_ready, rsp_valid, rsp_xita, rsp_err, core_start, core_tan
    );

    modport master (
        output req_valid, req_tan, rsp_ready, core_valid, core_xita,
        input  req_ready, rsp_valid, rsp_xita, rsp_err, core_start, core_tan
    );
endinterface

// File: rtl/arctan_scheduler_rr_arbiter.sv
// Cyclic priority arbiter: first set request at or after ptr_i wins. Purely
// combinational; the owner decides when and how to move the pointer.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);
    localparam int IW = $clog2(N);

    // Scan from the farthest slot down to the pointer so the nearest request is written last.
    always_comb begin
        logic [IW-1:0] j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = j;
                any_o    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/arctan_scheduler.sv
// Shares one iterative arctan core among N requesters: round-robin grant, one-cycle
// start, wait for the core, return xita to the winner. Optional WAIT timeout: ARCTAN_SCHED_TIMEOUT_EN.
module arctan_scheduler
    import arctan_scheduler_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
`ifdef ARCTAN_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
    input  logic              clk,
    input  logic              rst,
    arctan_scheduler_if.slave bus_io
);
    localparam int IW = $clog2(N);

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic [W-1:0]  tan_q, tan_d;
    logic [W-1:0]  xita_q, xita_d;
    logic [N-1:0]  rv_q, rv_d;
    logic          err_q, err_d;

    logic [N-1:0]  gnt;
    logic [IW-1:0] gidx;
    logic          gany;
    logic [N-1:0]  req_rdy;
    logic          start;
    logic          tmo;

    rr_arbiter #(.N(N)) u_arb (
        .req_i (bus_io.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (gany)
    );

`ifdef ARCTAN_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter is zero on WAIT entry, so hitting TIMEOUT-1 marks the TIMEOUT-th WAIT cycle.
    always_comb begin
        cnt_d = '0;
        if (state_q == S_WAIT) cnt_d = cnt_q + 1'b1;
    end
    assign tmo = (state_q == S_WAIT) && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        tan_d   = tan_q;
        xita_d  = xita_q;
        rv_d    = rv_q;
        err_d   = err_q;
        req_rdy = '0;
        start   = 1'b0;
        unique case (state_q)
            S_IDLE: if (gany) begin
                req_rdy = gnt;
                tan_d   = bus_io.req_tan[gidx];
                gidx_d  = gidx;
                ptr_d   = (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                start   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: if (bus_io.core_valid || tmo) begin
                xita_d       = bus_io.core_valid ? bus_io.core_xita : '0;
                err_d        = !bus_io.core_valid;
                rv_d         = '0;
                rv_d[gidx_q] = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: if (bus_io.rsp_ready[gidx_q]) begin
                rv_d    = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            tan_q   <= '0;
            xita_q  <= '0;
            rv_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            tan_q   <= tan_d;
            xita_q  <= xita_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
        end
    end

    // The arbiter would otherwise advertise a grant while reset holds the FSM in IDLE.
    assign bus_io.req_ready  = rst ? '0 : req_rdy;
    assign bus_io.core_start = start;
    assign bus_io.core_tan   = tan_q;
    assign bus_io.rsp_valid  = rv_q;
    assign bus_io.rsp_xita   = xita_q;
    assign bus_io.rsp_err    = err_q;
endmodule

// File: tb/tb_arctan_scheduler.sv
// Bench for arctan_scheduler: behavioural 16-cycle core model plus a scoreboard that
// pushes the expected xita at each grant and checks it at each response handshake.
module tb_arctan_scheduler;
    import arctan_scheduler_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arctan_scheduler_if #(.N(N), .W(W)) bus ();
    arctan_scheduler #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus_io(bus));

    int checks = 0;
    int passes = 0;

    function automatic logic [W-1:0] f_xita(input logic [W-1:0] t);
        return (t ^ 32'h1357_9BDF) + W'(K);
    endfunction

    // Core model: result appears 16 cycles after the start pulse; ignores the scheduler reset.
    bit           core_dead   = 1'b0;
    bit           force_valid = 1'b0;
    logic         mdl_valid   = 1'b0;
    logic [W-1:0] mdl_xita    = '0;
    logic [W-1:0] mdl_tan     = '0;
    bit           mdl_busy    = 1'b0;
    int           mdl_cnt     = 0;

    always @(posedge clk) begin
        mdl_valid <= 1'b0;
        if (bus.core_start && !core_dead) begin
            mdl_busy <= 1'b1;
            mdl_cnt  <= 1;
            mdl_tan  <= bus.core_tan;
        end else if (mdl_busy) begin
            if (mdl_cnt == 15) begin
                mdl_valid <= 1'b1;
                mdl_xita  <= f_xita(mdl_tan);
                mdl_busy  <= 1'b0;
            end else begin
                mdl_cnt <= mdl_cnt + 1;
            end
        end
    end
    assign bus.core_valid = mdl_valid | force_valid;
    assign bus.core_xita  = force_valid ? 32'hDEAD_BEEF : mdl_xita;

    logic [W-1:0] exp_x_q[$];
    bit           exp_e_q[$];
    int           exp_g_q[$];
    int           grant_log[$];

    always @(negedge clk) begin
        int           g;
        logic [W-1:0] x;
        bit           e;
        logic [N-1:0] oh;
        if (rst) begin
            exp_x_q.delete();
            exp_e_q.delete();
            exp_g_q.delete();
        end else begin
            if (|bus.req_ready) begin
                g = 0;
                for (int i = 0; i < N; i++) if (bus.req_ready[i]) g = i;
                checks++;
                if (!$onehot(bus.req_ready) || ((bus.req_ready & ~bus.req_valid) != '0))
                    $display("FAIL grant_onehot: req_ready=%b req_valid=%b", bus.req_ready, bus.req_valid);
                else passes++;
                grant_log.push_back(g);
                exp_g_q.push_back(g);
                exp_e_q.push_back(core_dead);
                exp_x_q.push_back(core_dead ? '0 : f_xita(bus.req_tan[g]));
            end
            if (|(bus.rsp_valid & bus.rsp_ready)) begin
                checks++;
                if (exp_x_q.size() == 0) begin
                    $display("FAIL rsp_unexpected: rsp_valid=%b with empty scoreboard", bus.rsp_valid);
                end else begin
                    passes++;
                    x = exp_x_q.pop_front();
                    e = exp_e_q.pop_front();
                    g = exp_g_q.pop_front();
                    oh = '0;
                    oh[g] = 1'b1;
                    checks++;
                    if (bus.rsp_xita !== x) $display("FAIL rsp_xita: got %h want %h", bus.rsp_xita, x);
                    else passes++;
                    checks++;
                    if (bus.rsp_err !== e) $display("FAIL rsp_err: got %b want %b", bus.rsp_err, e);
                    else passes++;
                    checks++;
                    if (bus.rsp_valid !== oh) $display("FAIL rsp_owner: got %b want %b", bus.rsp_valid, oh);
                    else passes++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_grant(input int i, output int n);
        #1;
        n = 0;
        while (!bus.req_ready[i] && n < 100) begin tick(); n++; end
    endtask

    task automatic wait_rsp(input int i, input int lim, output int n);
        n = 0;
        while (!bus.rsp_valid[i] && n < lim) begin tick(); n++; end
    endtask

    task automatic drain(input string name);
        int n = 0;
        bus.rsp_ready = '1;
        while (exp_x_q.size() != 0 && n < 300) begin tick(); n++; end
        bus.rsp_ready = '0;
        checks++;
        if (exp_x_q.size() != 0) $display("FAIL %s_drain: %0d responses outstanding", name, exp_x_q.size());
        else passes++;
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        bus.rsp_ready = '0;
        bus.req_tan   = '0;
        repeat (2) tick();
        checks++; if (bus.req_ready !== '0) $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); else passes++;
        checks++; if (bus.rsp_valid !== '0) $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); else passes++;
        checks++; if (bus.rsp_xita !== '0) $display("FAIL rst_rsp_xita: got %h want 0", bus.rsp_xita); else passes++;
        checks++; if (bus.rsp_err !== 1'b0) $display("FAIL rst_rsp_err: got %b want 0", bus.rsp_err); else passes++;
        checks++; if (bus.core_start !== 1'b0) $display("FAIL rst_core_start: got %b want 0", bus.core_start); else passes++;
        checks++; if (bus.core_tan !== '0) $display("FAIL rst_core_tan: got %h want 0", bus.core_tan); else passes++;
        bus.req_valid = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n;
        bus.req_tan[0] = ONE;
        bus.req_valid  = 4'b0001;
        wait_grant(0, n);
        checks++; if (n != 0) $display("FAIL single_grant: waited %0d want 0", n); else passes++;
        tick();
        bus.req_valid = '0;
        checks++; if (bus.core_start !== 1'b1) $display("FAIL single_start: got %b want 1", bus.core_start); else passes++;
        checks++; if (bus.core_tan !== ONE) $display("FAIL single_core_tan: got %h want %h", bus.core_tan, ONE); else passes++;
        wait_rsp(0, 100, n);
        checks++; if (n != 17) $display("FAIL single_latency: got %0d want 17", n); else passes++;
        checks++; if (bus.rsp_xita !== f_xita(ONE)) $display("FAIL single_xita: got %h want %h", bus.rsp_xita, f_xita(ONE)); else passes++;
        bus.rsp_ready = 4'b0001;
        tick();
        bus.rsp_ready = '0;
        checks++; if (bus.rsp_valid !== '0) $display("FAIL single_clear: got %b want 0", bus.rsp_valid); else passes++;
    endtask

    task automatic test_rr_order();
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        int n = 0;
        do_reset();
        grant_log.delete();
        bus.req_tan[0] = 32'd113512;
        bus.req_tan[1] = 32'd37837;
        bus.req_tan[2] = 32'h8001_0000;
        bus.req_tan[3] = 32'h0036_9AAA;
        bus.rsp_ready  = '1;
        bus.req_valid  = '1;
        while (grant_log.size() < 5 && n < 500) begin tick(); n++; end
        bus.req_valid = '0;
        checks++; if (grant_log.size() != 5) $display("FAIL rr_count: got %0d grants want 5", grant_log.size()); else passes++;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (k >= grant_log.size()) $display("FAIL rr_order[%0d]: got none want %0d", k, exp_ord[k]);
            else if (grant_log[k] != exp_ord[k]) $display("FAIL rr_order[%0d]: got %0d want %0d", k, grant_log[k], exp_ord[k]);
            else passes++;
        end
        drain("rr");
    endtask

    task automatic test_hold();
        int n;
        logic [W-1:0] x0;
        bit bad;
        bus.req_tan[1] = 32'h0000_8000;
        bus.req_valid  = 4'b0010;
        wait_grant(1, n);
        tick();
        bus.req_tan[2] = 32'h0002_0000;
        bus.req_valid  = 4'b0100;
        bus.rsp_ready  = 4'b1101;
        wait_rsp(1, 100, n);
        x0 = bus.rsp_xita;
        for (int c = 0; c < 5; c++) begin
            tick();
            bad = (bus.rsp_valid !== 4'b0010) || (bus.rsp_xita !== x0) || (bus.core_start !== 1'b0) || (bus.req_ready !== '0);
            checks++;
            if (bad) $display("FAIL hold[%0d]: rsp_valid=%b xita=%h start=%b req_ready=%b want 0010/%h/0/0000",
                              c, bus.rsp_valid, bus.rsp_xita, bus.core_start, bus.req_ready, x0);
            else passes++;
        end
        bus.rsp_ready = 4'b0010;
        tick();
        bus.rsp_ready = '0;
        checks++; if (bus.req_ready !== 4'b0100) $display("FAIL hold_next_grant: got %b want 0100", bus.req_ready); else passes++;
        tick();
        bus.req_valid = '0;
        checks++; if (bus.core_start !== 1'b1) $display("FAIL hold_next_start: got %b want 1", bus.core_start); else passes++;
        drain("hold");
    endtask

    task automatic test_reset_wait();
        int n;
        bit bad = 1'b0;
        bus.req_tan[1] = 32'h0003_0000;
        bus.req_valid  = 4'b0010;
        wait_grant(1, n);
        tick();
        bus.req_valid = '0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== '0 || bus.rsp_xita !== '0 || bus.rsp_err !== 1'b0 || bus.core_start !== 1'b0 ||
            bus.core_tan !== '0 || bus.req_ready !== '0)
            $display("FAIL rst_wait_outputs: rsp_valid=%b xita=%h err=%b start=%b core_tan=%h req_ready=%b want all 0",
                     bus.rsp_valid, bus.rsp_xita, bus.rsp_err, bus.core_start, bus.core_tan, bus.req_ready);
        else passes++;
        repeat (2) tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.rsp_valid !== '0) bad = 1'b1;
        end
        checks++; if (bad) $display("FAIL rst_stray_valid: got rsp_valid set want 0"); else passes++;
        bus.req_tan[2] = 32'h0004_0000;
        bus.req_valid  = 4'b0110;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) $display("FAIL rst_ptr: got %b want 0010", bus.req_ready); else passes++;
        tick();
        bus.req_valid = '0;
        drain("rst_wait");
    endtask

    task automatic test_core_valid_idle();
        int n;
        bit bad = 1'b0;
        force_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.rsp_valid !== '0) bad = 1'b1;
        end
        checks++; if (bad) $display("FAIL idle_core_valid: got rsp_valid set want 0"); else passes++;
        bus.req_tan[3] = 32'h0000_4000;
        bus.req_valid  = 4'b1000;
        wait_grant(3, n);
        tick();
        bus.req_valid = '0;
        checks++;
        if (bus.core_start !== 1'b1 || bus.rsp_valid !== '0)
            $display("FAIL issue_core_valid: start=%b rsp_valid=%b want 1/0000", bus.core_start, bus.rsp_valid);
        else passes++;
        tick();
        force_valid = 1'b0;
        checks++; if (bus.rsp_valid !== '0) $display("FAIL issue_ignored: got %b want 0000", bus.rsp_valid); else passes++;
        drain("forced");
    endtask

`ifdef ARCTAN_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        core_dead = 1'b1;
        bus.req_tan[0] = 32'h0005_0000;
        bus.req_valid  = 4'b0001;
        wait_grant(0, n);
        tick();
        bus.req_valid = '0;
        wait_rsp(0, 200, n);
        checks++; if (n != 65) $display("FAIL tmo_latency: got %0d want 65", n); else passes++;
        checks++; if (bus.rsp_err !== 1'b1) $display("FAIL tmo_err: got %b want 1", bus.rsp_err); else passes++;
        checks++; if (bus.rsp_xita !== '0) $display("FAIL tmo_xita: got %h want 0", bus.rsp_xita); else passes++;
        bus.rsp_ready = 4'b0001;
        tick();
        bus.rsp_ready = '0;
        checks++; if (bus.rsp_err !== 1'b0) $display("FAIL tmo_err_clear: got %b want 0", bus.rsp_err); else passes++;
        core_dead = 1'b0;
        bus.req_tan[1] = 32'h0006_0000;
        bus.req_valid  = 4'b0010;
        wait_grant(1, n);
        tick();
        bus.req_valid = '0;
        drain("tmo_after");
    endtask
`endif

    initial begin
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        bus.req_tan   = '0;
        test_reset();
        test_single();
        test_rr_order();
        test_hold();
        test_reset_wait();
        test_core_valid_idle();
`ifdef ARCTAN_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
